// File: rtl/univ_shift_reg_pkg.sv
// Shared mode encodings for the universal shift register.
// Imported by the RTL and by benches driving the mode port.
package univ_shift_reg_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_CLR  = 3'b110;

endpackage

// File: rtl/univ_shift_reg_shift_cnt.sv
// Saturating shift counter with clear and a one-cycle done pulse.
// done fires only on the WIDTH-1 -> WIDTH transition.
module shift_cnt #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(WIDTH - 1);

    // count shifts, saturate at WIDTH, pulse done on arrival
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clr) begin
                cnt <= '0;
            end else if (inc) begin
                if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                if (cnt == CNT_PRE) done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift, load, rotate, clear.
// Rotate modes exist only when ROTATE_EN is defined; else they hold.
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] par_in,
    input  logic             ser_in_l,
    input  logic             ser_in_r,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_l,
    output logic             ser_out_r,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    logic [WIDTH-1:0] q_nxt;
    logic             cnt_clr;
    logic             cnt_inc;

    // mode decode: next register value and counter control
    always_comb begin
        q_nxt   = q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        if (en) begin
            case (mode)
                MODE_SHL: begin
                    q_nxt   = {q[WIDTH-2:0], ser_in_l};
                    cnt_inc = 1'b1;
                end
                MODE_SHR: begin
                    q_nxt   = {ser_in_r, q[WIDTH-1:1]};
                    cnt_inc = 1'b1;
                end
                MODE_LOAD: begin
                    q_nxt   = par_in;
                    cnt_clr = 1'b1;
                end
`ifdef ROTATE_EN
                MODE_ROL: begin
                    q_nxt   = {q[WIDTH-2:0], q[WIDTH-1]};
                    cnt_inc = 1'b1;
                end
                MODE_ROR: begin
                    q_nxt   = {q[0], q[WIDTH-1:1]};
                    cnt_inc = 1'b1;
                end
`endif
                MODE_CLR: begin
                    q_nxt   = '0;
                    cnt_clr = 1'b1;
                end
                default: begin
                    q_nxt = q;
                end
            endcase
        end
    end

    // register contents
    always_ff @(posedge clk) begin
        if (!rst) q <= '0;
        else      q <= q_nxt;
    end

    assign ser_out_l = q[WIDTH-1];
    assign ser_out_r = q[0];

    shift_cnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .cnt  (cnt),
        .done (done)
    );

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg at WIDTH=4.
// Rotate checks follow ROTATE_EN; otherwise rotate codes must hold.
module tb_univ_shift_reg;
    import univ_shift_reg_pkg::*;

    localparam int W  = 4;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [2:0]    mode;
    logic [W-1:0]  par_in;
    logic          ser_in_l;
    logic          ser_in_r;
    logic [W-1:0]  q;
    logic          ser_out_l;
    logic          ser_out_r;
    logic [CW-1:0] cnt;
    logic          done;

    int checks = 0;
    int errors = 0;

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .par_in    (par_in),
        .ser_in_l  (ser_in_l),
        .ser_in_r  (ser_in_r),
        .q         (q),
        .ser_out_l (ser_out_l),
        .ser_out_r (ser_out_r),
        .cnt       (cnt),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [2:0] m,
                        input logic [W-1:0] p, input logic sl,
                        input logic sr);
        rst      = r;
        en       = e;
        mode     = m;
        par_in   = p;
        ser_in_l = sl;
        ser_in_r = sr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk3(input string tag, input logic [W-1:0] eq,
                        input logic [CW-1:0] ec, input logic ed);
        check({tag, ".q"},    32'(q),    32'(eq));
        check({tag, ".cnt"},  32'(cnt),  32'(ec));
        check({tag, ".done"}, 32'(done), 32'(ed));
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; mode = MODE_HOLD;
        par_in = '0; ser_in_l = 1'b0; ser_in_r = 1'b0;
        step(1'b0, 1'b0, MODE_HOLD, 4'h0, 1'b0, 1'b0);
        chk3("por", 4'b0000, 3'd0, 1'b0);

        // 1: reset from q=1111, cnt=3
        step(1'b1, 1'b1, MODE_LOAD, 4'b1111, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, MODE_SHL, 4'h0, 1'b1, 1'b0);
        chk3("pre_rst", 4'b1111, 3'd3, 1'b0);
        step(1'b0, 1'b1, MODE_SHL, 4'h0, 1'b1, 1'b0);
        chk3("rst", 4'b0000, 3'd0, 1'b0);

        // 2: load then shift left
        step(1'b1, 1'b1, MODE_LOAD, 4'b1010, 1'b0, 1'b0);
        chk3("load", 4'b1010, 3'd0, 1'b0);
        step(1'b1, 1'b1, MODE_SHL, 4'h0, 1'b1, 1'b0);
        chk3("shl", 4'b0101, 3'd1, 1'b0);
        check("shl.sol", 32'(ser_out_l), 32'd0);
        check("shl.sor", 32'(ser_out_r), 32'd1);

        // HOLD leaves everything alone
        step(1'b1, 1'b1, MODE_HOLD, 4'hF, 1'b1, 1'b1);
        chk3("hold", 4'b0101, 3'd1, 1'b0);

`ifdef ROTATE_EN
        // 3: rotate right four times and once more
        step(1'b1, 1'b1, MODE_LOAD, 4'b1011, 1'b0, 1'b0);
        step(1'b1, 1'b1, MODE_ROR, 4'h0, 1'b0, 1'b0);
        chk3("ror1", 4'b1101, 3'd1, 1'b0);
        step(1'b1, 1'b1, MODE_ROR, 4'h0, 1'b0, 1'b0);
        chk3("ror2", 4'b1110, 3'd2, 1'b0);
        step(1'b1, 1'b1, MODE_ROR, 4'h0, 1'b0, 1'b0);
        chk3("ror3", 4'b0111, 3'd3, 1'b0);
        step(1'b1, 1'b1, MODE_ROR, 4'h0, 1'b0, 1'b0);
        chk3("ror4", 4'b1011, 3'd4, 1'b1);
        step(1'b1, 1'b1, MODE_ROR, 4'h0, 1'b0, 1'b0);
        chk3("ror5", 4'b1101, 3'd4, 1'b0);
        step(1'b1, 1'b1, MODE_ROL, 4'h0, 1'b0, 1'b0);
        chk3("rol", 4'b1011, 3'd4, 1'b0);
`else
        // 6b: rotate codes hold without ROTATE_EN
        step(1'b1, 1'b1, MODE_LOAD, 4'b1001, 1'b0, 1'b0);
        step(1'b1, 1'b1, MODE_SHR, 4'h0, 1'b0, 1'b1);
        chk3("pre_rot", 4'b1100, 3'd1, 1'b0);
        step(1'b1, 1'b1, MODE_ROL, 4'h0, 1'b1, 1'b1);
        chk3("rol_off", 4'b1100, 3'd1, 1'b0);
        step(1'b1, 1'b1, MODE_ROR, 4'h0, 1'b1, 1'b1);
        chk3("ror_off", 4'b1100, 3'd1, 1'b0);
`endif

        // 4: clear then fill from the left end
        step(1'b1, 1'b1, MODE_CLR, 4'h0, 1'b0, 1'b0);
        chk3("clr", 4'b0000, 3'd0, 1'b0);
        step(1'b1, 1'b1, MODE_SHR, 4'h0, 1'b0, 1'b1);
        chk3("shr1", 4'b1000, 3'd1, 1'b0);
        step(1'b1, 1'b1, MODE_SHR, 4'h0, 1'b0, 1'b1);
        chk3("shr2", 4'b1100, 3'd2, 1'b0);
        step(1'b1, 1'b1, MODE_SHR, 4'h0, 1'b0, 1'b1);
        chk3("shr3", 4'b1110, 3'd3, 1'b0);
        step(1'b1, 1'b1, MODE_SHR, 4'h0, 1'b0, 1'b1);
        chk3("shr4", 4'b1111, 3'd4, 1'b1);
        check("shr4.sor", 32'(ser_out_r), 32'd1);
        step(1'b1, 1'b1, MODE_SHR, 4'h0, 1'b0, 1'b0);
        chk3("shr_sat", 4'b0111, 3'd4, 1'b0);

        // 5: disabled load, reserved mode
        step(1'b1, 1'b0, MODE_LOAD, 4'b0110, 1'b0, 1'b0);
        chk3("en0", 4'b0111, 3'd4, 1'b0);
        step(1'b1, 1'b1, 3'b111, 4'b0110, 1'b1, 1'b1);
        chk3("rsvd", 4'b0111, 3'd4, 1'b0);

        // 6: reset mid-sequence drops the partial count
        step(1'b1, 1'b1, MODE_LOAD, 4'b0011, 1'b0, 1'b0);
        step(1'b1, 1'b1, MODE_SHL, 4'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, MODE_SHL, 4'h0, 1'b0, 1'b0);
        chk3("mid", 4'b1100, 3'd2, 1'b0);
        step(1'b0, 1'b1, MODE_SHL, 4'h0, 1'b0, 1'b0);
        chk3("mid_rst", 4'b0000, 3'd0, 1'b0);
        step(1'b1, 1'b1, MODE_SHL, 4'h0, 1'b1, 1'b0);
        step(1'b1, 1'b1, MODE_SHL, 4'h0, 1'b1, 1'b0);
        chk3("post_rst", 4'b0011, 3'd2, 1'b0);
        step(1'b1, 1'b1, MODE_SHL, 4'h0, 1'b1, 1'b0);
        chk3("post3", 4'b0111, 3'd3, 1'b0);
        step(1'b1, 1'b1, MODE_SHL, 4'h0, 1'b0, 1'b0);
        chk3("post4", 4'b1110, 3'd4, 1'b1);
        check("post4.sol", 32'(ser_out_l), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
